// File: rtl/tetris_move_sequencer.sv
// Tetris move sequencer: owns the locked playfield and the single falling
// piece, serialises player and gravity moves with collision checks, merges
// the piece into the field when it cannot fall, then clears full rows.
module tetris_move_sequencer #(
  parameter int ROWS      = 20,
  parameter int COLS      = 10,
  parameter int SPAWN_ROW = 19
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      spawn_valid,
  input  logic [2:0][COLS-1:0]      spawn_shape,
  output logic                      spawn_ready,
  input  logic                      req_left,
  input  logic                      req_right,
  input  logic                      req_drop,
  input  logic                      gravity_tick,
  output logic [ROWS-1:0][COLS-1:0] screen,
  output logic                      piece_active,
  output logic                      lock_pulse,
  output logic                      lines_valid,
  output logic [2:0]                lines_cleared,
  output logic                      game_over
);
  // Wide enough to hold ROWS itself, which terminates the clear scan.
  localparam int RW = $clog2(ROWS + 1);

  typedef logic [ROWS-1:0][COLS-1:0] field_t;
  typedef logic [2:0][COLS-1:0]      shape_t;

  typedef enum logic [2:0] {
    S_EMPTY, S_SPAWN_CHK, S_ACTIVE, S_EVAL, S_LOCK, S_CLEAR, S_GAME_OVER
  } state_e;

  typedef enum logic [1:0] {MV_LEFT, MV_RIGHT, MV_DOWN, MV_DROP} move_e;

  // Bit positions inside the pending-request vector.
  localparam int P_LEFT  = 0;
  localparam int P_RIGHT = 1;
  localparam int P_GRAV  = 2;
  localparam int P_DROP  = 3;

  state_e        state_q, state_d;
  move_e         move_q, move_d;
  field_t        field_q, field_d;
  shape_t        pshape_q, pshape_d;
  logic [RW-1:0] prow_q, prow_d;
  logic [RW-1:0] r_q, r_d;
  logic [3:0]    pend_q, pend_d;
  logic [2:0]    lines_q, lines_d;

  shape_t        shl, shr;
  logic          edge_l, edge_r, hit_l, hit_r, hit_dn, hit_here, dn_blocked;
  int            base;

  // Field row at a signed index; rows outside the playfield read as empty.
  function automatic logic [COLS-1:0] row_at(input field_t f, input int idx);
    if (idx >= 0 && idx < ROWS) return f[idx];
    return '0;
  endfunction

  // State register: the whole game state advances together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_EMPTY;
      move_q   <= MV_LEFT;
      // NOTE: the field is plain flops, not a RAM, so it is cleared on reset;
      // a stale field would leak blocks into the next game.
      field_q  <= '0;
      pshape_q <= '0;
      prow_q   <= RW'(SPAWN_ROW);
      r_q      <= '0;
      pend_q   <= '0;
      lines_q  <= '0;
    end else begin
      // NOTE: non-blocking here so every register samples pre-edge values.
      state_q  <= state_d;
      move_q   <= move_d;
      field_q  <= field_d;
      pshape_q <= pshape_d;
      prow_q   <= prow_d;
      r_q      <= r_d;
      pend_q   <= pend_d;
      lines_q  <= lines_d;
    end
  end

  // Next state: request arbitration, move/collision evaluation, lock, clear.
  always_comb begin
    // NOTE: every target gets a hold value first so no path infers a latch.
    state_d  = state_q;
    move_d   = move_q;
    field_d  = field_q;
    pshape_d = pshape_q;
    prow_d   = prow_q;
    r_d      = r_q;
    pend_d   = pend_q;
    lines_d  = lines_q;

    // pshape[k] sits on row prow-2+k.
    base     = int'(prow_q) - 2;
    edge_l   = 1'b0;
    edge_r   = 1'b0;
    hit_l    = 1'b0;
    hit_r    = 1'b0;
    hit_dn   = 1'b0;
    hit_here = 1'b0;
    for (int k = 0; k < 3; k++) begin
      shl[k]   = pshape_q[k] << 1;
      shr[k]   = pshape_q[k] >> 1;
      edge_l   = edge_l | pshape_q[k][COLS-1];
      edge_r   = edge_r | pshape_q[k][0];
      hit_l    = hit_l    | (|(shl[k]      & row_at(field_q, base + k)));
      hit_r    = hit_r    | (|(shr[k]      & row_at(field_q, base + k)));
      hit_here = hit_here | (|(pshape_q[k] & row_at(field_q, base + k)));
      hit_dn   = hit_dn   | (|(pshape_q[k] & row_at(field_q, base + k - 1)));
    end
    // Row 2 is the floor for the anchor even if the lower shape rows are empty.
    dn_blocked = (prow_q == RW'(2)) || hit_dn;

    unique case (state_q)
      S_EMPTY: begin
        if (spawn_valid) begin
          pshape_d = spawn_shape;
          prow_d   = RW'(SPAWN_ROW);
          state_d  = S_SPAWN_CHK;
        end
      end
      S_SPAWN_CHK: state_d = hit_here ? S_GAME_OVER : S_ACTIVE;
      S_ACTIVE: begin
        if (|pend_q) begin
          state_d = S_EVAL;
          if (pend_q[P_DROP]) begin
            move_d = MV_DROP;  pend_d[P_DROP]  = 1'b0;
          end else if (pend_q[P_GRAV]) begin
            move_d = MV_DOWN;  pend_d[P_GRAV]  = 1'b0;
          end else if (pend_q[P_LEFT]) begin
            move_d = MV_LEFT;  pend_d[P_LEFT]  = 1'b0;
          end else begin
            move_d = MV_RIGHT; pend_d[P_RIGHT] = 1'b0;
          end
        end
      end
      S_EVAL: begin
        unique case (move_q)
          MV_LEFT: begin
            if (!(edge_l || hit_l)) pshape_d = shl;
            state_d = S_ACTIVE;
          end
          MV_RIGHT: begin
            if (!(edge_r || hit_r)) pshape_d = shr;
            state_d = S_ACTIVE;
          end
          MV_DOWN: begin
            if (dn_blocked) state_d = S_LOCK;
            else begin
              prow_d  = prow_q - RW'(1);
              state_d = S_ACTIVE;
            end
          end
          MV_DROP: begin
            // Hard drop stays here, one row per cycle, until it lands.
            if (dn_blocked) state_d = S_LOCK;
            else            prow_d  = prow_q - RW'(1);
          end
        endcase
      end
      S_LOCK: begin
        for (int j = 0; j < ROWS; j++)
          for (int k = 0; k < 3; k++)
            if (j == base + k) field_d[j] = field_d[j] | pshape_q[k];
        pend_d  = '0;
        lines_d = '0;
        r_d     = '0;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (r_q == RW'(ROWS)) begin
          state_d = S_EMPTY;
        end else if (&field_q[r_q]) begin
          // Collapse rows above r; r stays put to re-test the row that fell in.
          for (int j = 0; j < ROWS - 1; j++)
            if (j >= int'(r_q)) field_d[j] = field_q[j+1];
          field_d[ROWS-1] = '0;
          lines_d         = lines_q + 3'd1;
        end else begin
          r_d = r_q + RW'(1);
        end
      end
      S_GAME_OVER: state_d = S_GAME_OVER;
      default:     state_d = S_EMPTY;
    endcase

    // Requests are captured only while a piece is live; a new pulse wins over
    // the clear of the flag being serviced in the same cycle.
    if (state_q == S_ACTIVE || state_q == S_EVAL)
      pend_d = pend_d | {req_drop, gravity_tick, req_right, req_left};
  end

  // Outputs: decoded from state, screen overlays the live piece on the field.
  always_comb begin
    spawn_ready   = (state_q == S_EMPTY);
    piece_active  = (state_q == S_ACTIVE) || (state_q == S_EVAL);
    lock_pulse    = (state_q == S_LOCK);
    lines_valid   = (state_q == S_CLEAR) && (r_q == RW'(ROWS));
    lines_cleared = lines_q;
    game_over     = (state_q == S_GAME_OVER);
    screen        = field_q;
    if (piece_active)
      for (int j = 0; j < ROWS; j++)
        for (int k = 0; k < 3; k++)
          if (j == int'(prow_q) - 2 + k) screen[j] = screen[j] | pshape_q[k];
  end

endmodule

// File: tb/tb_tetris_move_sequencer.sv
// Bench for tetris_move_sequencer: directed scenarios plus randomized games,
// checked against a cell-list model of the playfield and falling piece.
module tb_tetris_move_sequencer;
  typedef logic [2:0][9:0]  shape_t;
  typedef logic [19:0][9:0] field_t;
  typedef struct {
    int          lines;
    logic [199:0] field;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         spawn_valid;
  shape_t       spawn_shape;
  logic         spawn_ready;
  logic         req_left, req_right, req_drop, gravity_tick;
  field_t       screen;
  logic         piece_active, lock_pulse, lines_valid;
  logic [2:0]   lines_cleared;
  logic         game_over;

  tetris_move_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .spawn_valid  (spawn_valid),
    .spawn_shape  (spawn_shape),
    .spawn_ready  (spawn_ready),
    .req_left     (req_left),
    .req_right    (req_right),
    .req_drop     (req_drop),
    .gravity_tick (gravity_tick),
    .screen       (screen),
    .piece_active (piece_active),
    .lock_pulse   (lock_pulse),
    .lines_valid  (lines_valid),
    .lines_cleared(lines_cleared),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: locked field as rows, piece as a list of occupied cells.
  bit [9:0] mf [20];
  int       cr[$];
  int       cc[$];
  int       anchor;
  bit       mactive;
  exp_t     sbq[$];
  int       exp_locks  = 0;
  int       seen_locks = 0;
  exp_t     mon_e;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [199:0] m_field();
    field_t v;
    for (int i = 0; i < 20; i++) v[i] = mf[i];
    return 200'(v);
  endfunction

  function automatic logic [199:0] m_screen();
    field_t v;
    for (int i = 0; i < 20; i++) v[i] = mf[i];
    if (mactive) foreach (cr[i]) v[cr[i]][cc[i]] = 1'b1;
    return 200'(v);
  endfunction

  function automatic bit fits(input int dr, input int dc);
    int r, c;
    foreach (cr[i]) begin
      r = cr[i] + dr;
      c = cc[i] + dc;
      if (r < 0 || r > 19 || c < 0 || c > 9) return 1'b0;
      if (mf[r][c]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic m_shift(input int dr, input int dc);
    foreach (cr[i]) begin
      cr[i] = cr[i] + dr;
      cc[i] = cc[i] + dc;
    end
  endtask

  task automatic m_clear_all();
    for (int i = 0; i < 20; i++) mf[i] = '0;
    cr.delete();
    cc.delete();
    mactive = 1'b0;
    sbq.delete();
  endtask

  task automatic m_spawn(input shape_t sh, output bit over);
    over = 1'b0;
    cr.delete();
    cc.delete();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 10; c++)
        if (sh[k][c]) begin
          cr.push_back(17 + k);
          cc.push_back(c);
          if (mf[17 + k][c]) over = 1'b1;
        end
    anchor  = 19;
    mactive = !over;
  endtask

  // Merge the piece, drop every full row, queue the expected clear result.
  task automatic m_lock();
    bit [9:0] nf [20];
    int       n = 0;
    exp_t     e;
    e.lines = 0;
    foreach (cr[i]) mf[cr[i]][cc[i]] = 1'b1;
    for (int i = 0; i < 20; i++) nf[i] = '0;
    for (int i = 0; i < 20; i++)
      if (mf[i] == 10'h3ff) e.lines++;
      else begin
        nf[n] = mf[i];
        n++;
      end
    for (int i = 0; i < 20; i++) mf[i] = nf[i];
    e.field = m_field();
    sbq.push_back(e);
    exp_locks++;
    mactive = 1'b0;
  endtask

  task automatic m_down(output bit locked);
    if (anchor == 2 || !fits(-1, 0)) begin
      m_lock();
      locked = 1'b1;
    end else begin
      m_shift(-1, 0);
      anchor--;
      locked = 1'b0;
    end
  endtask

  task automatic m_left();
    if (fits(0, 1)) m_shift(0, 1);
  endtask

  task automatic m_right();
    if (fits(0, -1)) m_shift(0, -1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    spawn_valid = 1'b0; req_left = 1'b0; req_right = 1'b0;
    req_drop = 1'b0; gravity_tick = 1'b0;
    tick(2);
    reset = 1'b0;
    m_clear_all();
  endtask

  task automatic do_spawn(input shape_t sh, output bit over);
    int w = 0;
    while (!spawn_ready && w < 100) begin
      tick(1);
      w++;
    end
    check("spawn_ready_idle", 200'(spawn_ready), 200'(1));
    spawn_valid = 1'b1;
    spawn_shape = sh;
    tick(1);
    spawn_valid = 1'b0;
    m_spawn(sh, over);
    check("spawn_ready_drop", 200'(spawn_ready), 200'(0));
    check("piece_active_t1", 200'(piece_active), 200'(0));
    tick(1);
    check("piece_active_t2", 200'(piece_active), 200'(!over));
    check("game_over_spawn", 200'(game_over), 200'(over));
    check("screen_spawn", 200'(screen), m_screen());
  endtask

  // Issue one cycle of request pulses, model them in priority order, settle.
  task automatic do_moves(input bit l, input bit r, input bit g, input bit d, output bit locked);
    int w = 0;
    req_left = l; req_right = r; gravity_tick = g; req_drop = d;
    tick(1);
    req_left = 1'b0; req_right = 1'b0; gravity_tick = 1'b0; req_drop = 1'b0;
    locked = 1'b0;
    if (d) begin
      while (!locked) m_down(locked);
    end else begin
      if (g) m_down(locked);
      if (!locked && l) m_left();
      if (!locked && r) m_right();
    end
    if (locked) begin
      while (!spawn_ready && w < 300) begin
        tick(1);
        w++;
      end
      check("lock_settle_in_time", 200'(spawn_ready), 200'(1));
      check("scoreboard_drained", 200'(sbq.size()), 200'(0));
      check("field_after_lock", 200'(screen), m_field());
    end else begin
      tick(7);
      check("piece_active_move", 200'(piece_active), 200'(1));
      check("screen_move", 200'(screen), m_screen());
    end
  endtask

  function automatic shape_t rand_shape();
    logic [8:0] pats [6];
    logic [8:0] p;
    int         off;
    shape_t     sh;
    pats[0] = 9'b001_001_001;
    pats[1] = 9'b111_000_000;
    pats[2] = 9'b100_100_110;
    pats[3] = 9'b111_010_000;
    pats[4] = 9'b110_110_000;
    pats[5] = 9'b011_110_000;
    p   = pats[$urandom_range(0, 5)];
    off = $urandom_range(0, 7);
    for (int k = 0; k < 3; k++) sh[k] = 10'(p[3*k +: 3]) << off;
    return sh;
  endfunction

  // Scoreboard monitor: each lines_valid must match the oldest queued lock.
  always @(negedge clk) begin
    if (!reset) begin
      if (lock_pulse) seen_locks++;
      if (lines_valid) begin
        if (sbq.size() == 0) begin
          check("lines_valid_unexpected", 200'(lines_valid), 200'(0));
        end else begin
          mon_e = sbq.pop_front();
          check("lines_cleared", 200'(lines_cleared), 200'(mon_e.lines));
          check("field_at_lines_valid", 200'(screen), mon_e.field);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    shape_t bar, block, ivert;
    bit     over, locked;
    int     w;
    bar   = '0; bar[2] = 10'b0000000111;
    block = '0;
    for (int k = 0; k < 3; k++) block[k] = 10'b1111111110;
    ivert = '0;
    for (int k = 0; k < 3; k++) ivert[k] = 10'b0000000001;

    // Reset state.
    do_reset();
    check("rst_spawn_ready", 200'(spawn_ready), 200'(1));
    check("rst_screen", 200'(screen), 200'(0));
    check("rst_piece_active", 200'(piece_active), 200'(0));
    check("rst_game_over", 200'(game_over), 200'(0));
    check("rst_lines", 200'({lock_pulse, lines_valid, lines_cleared}), 200'(0));

    // Bar at the right wall: right is blocked, three lefts walk it over.
    do_spawn(bar, over);
    check("bar_row19", 200'(screen[19]), 200'(10'b0000000111));
    do_moves(1'b0, 1'b1, 1'b0, 1'b0, locked);
    check("bar_right_blocked", 200'(screen[19]), 200'(10'b0000000111));
    for (int i = 0; i < 3; i++) begin
      req_left = 1'b1;
      tick(1);
      req_left = 1'b0;
      tick(1);
      m_left();
    end
    tick(6);
    check("bar_three_lefts", 200'(screen[19]), 200'(10'b0000111000));
    check("bar_three_lefts_model", 200'(screen), m_screen());

    // Gravity and left in one cycle: gravity first, left two cycles later.
    gravity_tick = 1'b1;
    req_left     = 1'b1;
    tick(1);
    gravity_tick = 1'b0;
    req_left     = 1'b0;
    tick(2);
    check("grav_first_row18", 200'(screen[18]), 200'(10'b0000111000));
    check("grav_first_row19", 200'(screen[19]), 200'(0));
    tick(2);
    check("left_after_grav", 200'(screen[18]), 200'(10'b0001110000));
    m_down(locked);
    m_left();
    check("grav_left_model", 200'(screen), m_screen());
    do_moves(1'b0, 1'b0, 1'b0, 1'b1, locked);

    // Three almost-full rows, then a vertical I in column 0 clears all three.
    do_reset();
    do_spawn(block, over);
    do_moves(1'b0, 1'b0, 1'b0, 1'b1, locked);
    check("block_landed", 200'(screen[2:0]), 200'({3{10'b1111111110}}));
    do_spawn(ivert, over);
    do_moves(1'b0, 1'b0, 1'b0, 1'b1, locked);
    check("three_lines_field_empty", 200'(screen), 200'(0));

    // Reset landing in the middle of the clear scan aborts it.
    do_spawn(block, over);
    do_moves(1'b0, 1'b0, 1'b0, 1'b1, locked);
    do_spawn(ivert, over);
    req_drop = 1'b1;
    tick(1);
    req_drop = 1'b0;
    m_down(locked);
    while (!locked) m_down(locked);
    w = 0;
    while (!lock_pulse && w < 100) begin
      tick(1);
      w++;
    end
    check("lock_pulse_seen", 200'(lock_pulse), 200'(1));
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    m_clear_all();
    check("clear_abort_screen", 200'(screen), 200'(0));
    check("clear_abort_ready", 200'(spawn_ready), 200'(1));
    check("clear_abort_no_lines", 200'(lines_valid), 200'(0));
    tick(30);

    // Stack blocks until a spawn collides; the game then freezes until reset.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_spawn(block, over);
      do_moves(1'b0, 1'b0, 1'b0, 1'b1, locked);
    end
    do_spawn(block, over);
    check("game_over_expected", 200'(over), 200'(1));
    spawn_valid = 1'b1; req_left = 1'b1; req_drop = 1'b1; gravity_tick = 1'b1;
    tick(3);
    spawn_valid = 1'b0; req_left = 1'b0; req_drop = 1'b0; gravity_tick = 1'b0;
    tick(20);
    check("game_over_sticky", 200'(game_over), 200'(1));
    check("game_over_no_ready", 200'(spawn_ready), 200'(0));
    check("game_over_frozen", 200'(screen), m_field());
    do_reset();
    check("game_over_reset", 200'(game_over), 200'(0));
    check("game_over_reset_screen", 200'(screen), 200'(0));

    // Randomized games.
    for (int p = 0; p < 40; p++) begin
      int n;
      do_spawn(rand_shape(), over);
      if (over) begin
        do_reset();
        continue;
      end
      locked = 1'b0;
      n = $urandom_range(0, 6);
      for (int s = 0; s < n && !locked; s++)
        do_moves(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), locked);
      if (!locked) do_moves(1'b0, 1'b0, 1'b0, 1'b1, locked);
    end

    tick(5);
    check("final_scoreboard_empty", 200'(sbq.size()), 200'(0));
    check("lock_pulse_count", 200'(seen_locks), 200'(exp_locks));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
